// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants and fetch FSM state type
package fetch_stage_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} fetch_state_e;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem fetch FSM and one-entry output buffer
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall_fetch,
  input  logic        i_pc_sel,
  input  logic [31:0] i_pc_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc_fetch,
  output logic [31:0] o_instr_fetch,
  output logic        o_valid_fetch
);
  fetch_state_e r_state;
  logic [31:0]  r_pc_q, r_pc_req, r_buf_pc, r_buf_instr;
  logic         r_kill, r_buf_valid;
  logic         w_consume, w_can_issue, w_grant, w_rv;
  assign w_consume     = r_buf_valid && !i_stall_fetch;
  assign w_can_issue   = !r_buf_valid || w_consume;
  assign o_imem_req    = (r_state == REQ) && w_can_issue;
  assign o_imem_addr   = r_pc_q;
  assign w_grant       = o_imem_req && i_imem_gnt;
  assign w_rv          = (r_state == WAIT) && i_imem_rvalid;
  assign o_valid_fetch = r_buf_valid;
  assign o_pc_fetch    = r_buf_valid ? r_buf_pc : 32'h0;
  assign o_instr_fetch = r_buf_valid ? r_buf_instr : NOP;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_pc_q      <= RESET_PC;
      r_pc_req    <= RESET_PC;
      r_kill      <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'h0;
      r_buf_instr <= NOP;
    end else begin
      r_state <= (r_state == IDLE) ? REQ :
                 (r_state == REQ)  ? (w_grant ? WAIT : REQ) :
                 (w_rv ? REQ : WAIT);
      r_pc_q <= i_pc_sel ? i_pc_target : w_grant ? r_pc_q + PC_INC : r_pc_q;
      if (w_grant) r_pc_req <= r_pc_q;
      // a redirect while a request is in flight marks its response as wrong-path
      if (w_rv) r_kill <= 1'b0;
      else if (i_pc_sel && (w_grant || r_state == WAIT)) r_kill <= 1'b1;
      if (i_pc_sel) r_buf_valid <= 1'b0;
      else if (w_rv && !r_kill) begin
        r_buf_valid <= 1'b1;
        r_buf_pc    <= r_pc_req;
        r_buf_instr <= i_imem_rdata;
      end else if (w_consume) r_buf_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: per-cycle directed vectors with hand-computed fetch stage outputs
module tb_fetch_stage;
  localparam logic [31:0] N = 32'h0000_0013;
  logic        i_clk, i_reset, i_stall_fetch, i_pc_sel, i_imem_gnt, i_imem_rvalid;
  logic [31:0] i_pc_target, i_imem_rdata;
  logic        o_imem_req, o_valid_fetch;
  logic [31:0] o_imem_addr, o_pc_fetch, o_instr_fetch;
  int          n_vec = 0, n_bad = 0;

  typedef struct {
    logic        rst, stall, sel;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, instr;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall_fetch(i_stall_fetch), .i_pc_sel(i_pc_sel),
    .i_pc_target(i_pc_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_pc_fetch(o_pc_fetch), .o_instr_fetch(o_instr_fetch), .o_valid_fetch(o_valid_fetch)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic vec_t mk(logic rst, logic stall, logic sel, logic [31:0] tgt, logic gnt,
                              logic rv, logic [31:0] rdata, logic req, logic [31:0] addr,
                              logic valid, logic [31:0] pc, logic [31:0] instr);
    vec_t v;
    v.rst = rst; v.stall = stall; v.sel = sel; v.tgt = tgt; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
    return v;
  endfunction

  task automatic apply(input string name, input vec_t v);
    @(negedge i_clk);
    i_reset = v.rst; i_stall_fetch = v.stall; i_pc_sel = v.sel; i_pc_target = v.tgt;
    i_imem_gnt = v.gnt; i_imem_rvalid = v.rv; i_imem_rdata = v.rdata;
    #1;
    n_vec++;
    if (o_imem_req !== v.req || o_imem_addr !== v.addr || o_valid_fetch !== v.valid ||
        o_pc_fetch !== v.pc || o_instr_fetch !== v.instr) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h instr=%h",
               name, o_imem_req, o_imem_addr, o_valid_fetch, o_pc_fetch, o_instr_fetch,
               v.req, v.addr, v.valid, v.pc, v.instr);
    end
  endtask

  initial begin
    //              rst st sel tgt            gnt rv rdata          req addr           v  pc             instr
    vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,             0, 0,             0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             0, 0,             0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 0,             0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h0,         0, 32'h4,         0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h4,         1, 32'h0,         32'h0));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h4,         0, 32'h8,         0, 0,             N));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 0, 0,           1, 0, 0,             0, 32'h8,         1, 32'h4,         32'h4));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h8,         1, 32'h4,         32'h4));
    vecs.push_back(mk(1, 0, 1, 32'h100,       0, 0, 0,             0, 32'hC,         0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,             0, 32'h100,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h8,         0, 32'h100,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h100,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h100,       0, 32'h104,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,             1, 32'h104,       1, 32'h100,       32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h200,       0, 0, 0,             1, 32'h104,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h200,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h200,       0, 32'h204,       0, 0,             N));
    vecs.push_back(mk(1, 1, 1, 32'h300,       1, 0, 0,             0, 32'h204,       1, 32'h200,       32'h200));
    vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,             1, 32'h300,       0, 0,             N));
    vecs.push_back(mk(1, 0, 1, 32'h400,       1, 0, 0,             1, 32'h300,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h300,       0, 32'h400,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h400,       0, 0,             N));
    vecs.push_back(mk(1, 0, 1, 32'h500,       0, 1, 32'h400,       0, 32'h404,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h500,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'h500,       0, 32'h504,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,             1, 32'h504,       1, 32'h500,       32'h500));
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0,             1, 32'h504,       0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'hFFFF_FFFC, 0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 0,             N));
    vecs.push_back(mk(1, 0, 0, 0,             1, 0, 0,             1, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
    i_reset = 1'b0; i_stall_fetch = 1'b0; i_pc_sel = 1'b0; i_pc_target = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    repeat (2) @(posedge i_clk);
    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);
    // reset lands while in WAIT; the response arriving during and after reset must be dropped
    apply("rst_in_wait",   mk(0, 0, 0, 0, 0, 0, 0,            0, 32'h4, 0, 0, N));
    apply("rst_rvalid",    mk(0, 0, 0, 0, 0, 1, 32'hDEAD,     0, 32'h0, 0, 0, N));
    apply("late_rvalid",   mk(1, 0, 0, 0, 0, 1, 32'hBEEF,     0, 32'h0, 0, 0, N));
    apply("req_reset_pc",  mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h0, 0, 0, N));
    apply("gnt_reset_pc",  mk(1, 0, 0, 0, 1, 0, 0,            1, 32'h0, 0, 0, N));
    apply("resp_reset_pc", mk(1, 0, 0, 0, 0, 1, 32'h13579BDF, 0, 32'h4, 0, 0, N));
    apply("buf_reset_pc",  mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h4, 1, 32'h0, 32'h13579BDF));
    apply("consumed",      mk(1, 0, 0, 0, 0, 0, 0,            1, 32'h4, 0, 0, N));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
